// File: rtl/concat_pkg.sv
// Shared definitions for the word/byte conversion paths: byte transform
// encodings and the unpacker state machine states.
package concat_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_SWAP = 2'b01,
      MODE_ROR  = 2'b10,
      MODE_ROL  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FIRST  = 2'b01,
      SECOND = 2'b10
   } state_t;

endpackage

// File: rtl/byte_transform.sv
// Purely combinational per-byte transform: pass, bit-swap, rotate right by 1,
// rotate left by 1. Shared with the forward concatenation path.
module byte_transform
   import concat_pkg::*;
(
   input  logic [7:0] b,
   input  mode_t      mode,
   output logic [7:0] y
);

   always_comb begin
      y = b;
      case (mode)
         MODE_PASS: y = b;
         MODE_SWAP: begin
            for (int i = 0; i < 8; i++) begin
               y[i] = b[7-i];
            end
         end
         MODE_ROR:  y = {b[0], b[7:1]};
         MODE_ROL:  y = {b[6:0], b[7]};
         default:   y = b;
      endcase
   end

endmodule

// File: rtl/word_unpacker.sv
// Splits 16-bit words into two transformed bytes with valid/ready on both
// sides; back-to-back words stream at one byte per cycle.
module word_unpacker
   import concat_pkg::*;
#(
   parameter int HIGH_FIRST = 1,
   parameter int CNT_W      = 8
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic [15:0]      WORD_IN,
   input  logic [1:0]       MODE,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [7:0]       BYTE_OUT,
   output logic [3:0]       HIGH_NIBBLE,
   output logic [3:0]       LOW_NIBBLE,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             OUT_LAST,
   output logic [CNT_W-1:0] BYTE_CNT
);

   // Handshake: a transfer happens on a side only in a cycle where both
   // valid and ready are high; the sender holds its data until then.

   state_t           state;
   logic [15:0]      word_r;
   mode_t            mode_r;
   logic [CNT_W-1:0] byte_cnt;
   logic             in_fire;
   logic             out_fire;
   logic [7:0]       first_byte;
   logic [7:0]       second_byte;
   logic [7:0]       raw_byte;
   logic [7:0]       xf_byte;

   assign OUT_VALID = (state != IDLE);
   assign OUT_LAST  = (state == SECOND);
   // Combinational OUT_READY -> IN_READY path lets the next word slip in
   // while the second byte leaves, so there is no bubble between words.
   assign IN_READY  = !RST && ((state == IDLE) || ((state == SECOND) && OUT_READY));
   assign in_fire   = IN_READY && IN_VALID;
   assign out_fire  = OUT_VALID && OUT_READY;
   assign BYTE_CNT  = byte_cnt;

   assign first_byte  = (HIGH_FIRST != 0) ? word_r[15:8] : word_r[7:0];
   assign second_byte = (HIGH_FIRST != 0) ? word_r[7:0]  : word_r[15:8];
   assign raw_byte    = (state == SECOND) ? second_byte : first_byte;

   byte_transform u_xf (
      .b    (raw_byte),
      .mode (mode_r),
      .y    (xf_byte)
   );

   assign BYTE_OUT    = OUT_VALID ? xf_byte : 8'h00;
   assign HIGH_NIBBLE = BYTE_OUT[7:4];
   assign LOW_NIBBLE  = BYTE_OUT[3:0];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         word_r   <= 16'h0000;
         mode_r   <= MODE_PASS;
         byte_cnt <= '0;
      end else begin
         if (out_fire) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
         end
         if (in_fire) begin
            word_r <= WORD_IN;
            mode_r <= mode_t'(MODE);
         end
         case (state)
            IDLE:    if (IN_VALID) state <= FIRST;
            FIRST:   if (OUT_READY) state <= SECOND;
            SECOND:  if (OUT_READY) state <= IN_VALID ? FIRST : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker: a high-first and a low-first instance
// share stimulus; table vectors plus hand-written multi-cycle sequences.
module tb_word_unpacker;

   logic        CLK;
   logic        RST;
   logic [15:0] WORD_IN;
   logic [1:0]  MODE;
   logic        IN_VALID;
   logic        OUT_READY;

   logic        hi_in_ready, hi_out_valid, hi_out_last;
   logic [7:0]  hi_byte, hi_cnt;
   logic [3:0]  hi_hn, hi_ln;
   logic        lo_in_ready, lo_out_valid, lo_out_last;
   logic [7:0]  lo_byte, lo_cnt;
   logic [3:0]  lo_hn, lo_ln;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_cnt;

   typedef struct {
      logic [15:0] word;
      logic [1:0]  mode;
      logic [7:0]  hi_b0;
      logic [7:0]  hi_b1;
   } vec_t;

   vec_t vecs[6];

   word_unpacker #(.HIGH_FIRST(1), .CNT_W(8)) dut_hi (
      .CLK(CLK), .RST(RST), .WORD_IN(WORD_IN), .MODE(MODE), .IN_VALID(IN_VALID),
      .IN_READY(hi_in_ready), .BYTE_OUT(hi_byte), .HIGH_NIBBLE(hi_hn),
      .LOW_NIBBLE(hi_ln), .OUT_VALID(hi_out_valid), .OUT_READY(OUT_READY),
      .OUT_LAST(hi_out_last), .BYTE_CNT(hi_cnt)
   );

   word_unpacker #(.HIGH_FIRST(0), .CNT_W(8)) dut_lo (
      .CLK(CLK), .RST(RST), .WORD_IN(WORD_IN), .MODE(MODE), .IN_VALID(IN_VALID),
      .IN_READY(lo_in_ready), .BYTE_OUT(lo_byte), .HIGH_NIBBLE(lo_hn),
      .LOW_NIBBLE(lo_ln), .OUT_VALID(lo_out_valid), .OUT_READY(OUT_READY),
      .OUT_LAST(lo_out_last), .BYTE_CNT(lo_cnt)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Checks one byte beat on both instances (lo expected byte given separately).
   task automatic check_beat(input string tag, input logic [7:0] hb, input logic [7:0] lb,
                             input logic last);
      check({tag, " hi_valid"}, {31'd0, hi_out_valid}, 32'd1);
      check({tag, " hi_byte"}, {24'd0, hi_byte}, {24'd0, hb});
      check({tag, " hi_nib"}, {24'd0, hi_hn, hi_ln}, {24'd0, hb});
      check({tag, " hi_last"}, {31'd0, hi_out_last}, {31'd0, last});
      check({tag, " lo_byte"}, {24'd0, lo_byte}, {24'd0, lb});
      check({tag, " lo_nib"}, {24'd0, lo_hn, lo_ln}, {24'd0, lb});
      check({tag, " lo_last"}, {31'd0, lo_out_last}, {31'd0, last});
   endtask

   task automatic check_idle(input string tag);
      check({tag, " hi_valid"}, {31'd0, hi_out_valid}, 32'd0);
      check({tag, " hi_byte0"}, {24'd0, hi_byte, hi_hn, hi_ln}, 32'd0);
      check({tag, " lo_valid"}, {31'd0, lo_out_valid}, 32'd0);
      check({tag, " lo_byte0"}, {24'd0, lo_byte, lo_hn, lo_ln}, 32'd0);
      check({tag, " last0"}, {30'd0, hi_out_last, lo_out_last}, 32'd0);
   endtask

   task automatic check_cnt(input string tag);
      check({tag, " hi_cnt"}, {24'd0, hi_cnt}, {24'd0, exp_cnt});
      check({tag, " lo_cnt"}, {24'd0, lo_cnt}, {24'd0, exp_cnt});
   endtask

   task automatic check_ready(input string tag, input logic exp);
      check({tag, " hi_in_ready"}, {31'd0, hi_in_ready}, {31'd0, exp});
      check({tag, " lo_in_ready"}, {31'd0, lo_in_ready}, {31'd0, exp});
   endtask

   logic all_valid;

   initial begin
      vecs[0] = '{16'hA53C, 2'b00, 8'hA5, 8'h3C};
      vecs[1] = '{16'h8101, 2'b01, 8'h81, 8'h80};
      vecs[2] = '{16'h8101, 2'b10, 8'hC0, 8'h80};
      vecs[3] = '{16'h8101, 2'b11, 8'h03, 8'h02};
      vecs[4] = '{16'hBEEF, 2'b00, 8'hBE, 8'hEF};
      vecs[5] = '{16'h8101, 2'b00, 8'h81, 8'h01};

      RST = 1'b1; WORD_IN = 16'h0; MODE = 2'b00; IN_VALID = 1'b0; OUT_READY = 1'b1;
      exp_cnt = 8'd0;
      #1;
      check_ready("reset", 1'b0);
      check_idle("reset");
      check_cnt("reset");
      tick(); tick();
      RST = 1'b0;
      #1;
      check_ready("post_reset", 1'b1);

      // table-driven single words; lo instance emits the same bytes swapped
      for (int i = 0; i < 6; i++) begin
         WORD_IN = vecs[i].word; MODE = vecs[i].mode; IN_VALID = 1'b1; OUT_READY = 1'b1;
         #1;
         check_ready($sformatf("v%0d idle", i), 1'b1);
         tick();
         IN_VALID = 1'b0; MODE = ~vecs[i].mode; WORD_IN = 16'hFFFF;
         #1;
         check_ready($sformatf("v%0d first", i), 1'b0);
         check_beat($sformatf("v%0d b0", i), vecs[i].hi_b0, vecs[i].hi_b1, 1'b0);
         tick();
         check_beat($sformatf("v%0d b1", i), vecs[i].hi_b1, vecs[i].hi_b0, 1'b1);
         check_ready($sformatf("v%0d second", i), 1'b1);
         tick();
         exp_cnt = exp_cnt + 8'd2;
         check_idle($sformatf("v%0d end", i));
         check_cnt($sformatf("v%0d", i));
      end

      // backpressure during FIRST: output frozen, mode/word changes ignored
      WORD_IN = 16'h1234; MODE = 2'b00; IN_VALID = 1'b1; OUT_READY = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         IN_VALID = 1'b1; WORD_IN = 16'(16'hF0F0 + c); MODE = 2'($urandom_range(1, 3));
         #1;
         check_beat($sformatf("bp%0d", c), 8'h12, 8'h34, 1'b0);
         check_ready($sformatf("bp%0d", c), 1'b0);
         check_cnt($sformatf("bp%0d", c));
         tick();
      end
      IN_VALID = 1'b0; OUT_READY = 1'b1;
      #1;
      check_beat("bp resume b0", 8'h12, 8'h34, 1'b0);
      tick();
      check_beat("bp resume b1", 8'h34, 8'h12, 1'b1);
      tick();
      exp_cnt = exp_cnt + 8'd2;
      check_idle("bp end");
      check_cnt("bp end");

      // back-to-back words with no bubble
      WORD_IN = 16'h1122; MODE = 2'b00; IN_VALID = 1'b1; OUT_READY = 1'b1;
      tick();
      WORD_IN = 16'h3344;
      #1;
      check_beat("b2b 11", 8'h11, 8'h22, 1'b0);
      tick();
      check_beat("b2b 22", 8'h22, 8'h11, 1'b1);
      check_ready("b2b second", 1'b1);
      tick();
      IN_VALID = 1'b0;
      #1;
      check_beat("b2b 33", 8'h33, 8'h44, 1'b0);
      tick();
      check_beat("b2b 44", 8'h44, 8'h33, 1'b1);
      tick();
      exp_cnt = exp_cnt + 8'd4;
      check_idle("b2b end");
      check_cnt("b2b end");

      // reset while in SECOND: everything cleared at once, no stale byte later
      WORD_IN = 16'h5566; IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      tick();
      check_beat("rst pre", 8'h66, 8'h55, 1'b1);
      RST = 1'b1;
      #1;
      exp_cnt = 8'd0;
      check_idle("rst mid");
      check_cnt("rst mid");
      check_ready("rst mid", 1'b0);
      tick();
      RST = 1'b0;
      #1;
      check_ready("rst release", 1'b1);
      tick();
      check_idle("rst after");
      check_cnt("rst after");

      // counter wrap: 256 bytes streamed back-to-back from zero
      WORD_IN = 16'h0F0F; MODE = 2'b00; IN_VALID = 1'b1; OUT_READY = 1'b1;
      tick();
      all_valid = 1'b1;
      for (int k = 0; k < 255; k++) begin
         all_valid = all_valid & hi_out_valid & lo_out_valid;
         tick();
         exp_cnt = exp_cnt + 8'd1;
      end
      IN_VALID = 1'b0;
      #1;
      check("wrap valid steady", {31'd0, all_valid}, 32'd1);
      check("wrap cnt 255", {24'd0, hi_cnt}, 32'd255);
      check_cnt("wrap 255");
      check_beat("wrap last", 8'h0F, 8'h0F, 1'b1);
      tick();
      exp_cnt = exp_cnt + 8'd1;
      check("wrap cnt 0", {24'd0, hi_cnt}, 32'd0);
      check_cnt("wrap 0");
      check_idle("wrap end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Serializes 16-bit words into a stream of bytes, splitting each word into its high and low bytes. This is the inverse of the team's byte-to-word concatenation path.
- An optional per-word byte transform is applied on the way out: pass, bit-swap, rotate-right or rotate-left.
- The output byte is also split into high and low nibbles.
- Sits between a word-wide producer and a byte-wide consumer, with valid/ready handshakes on both sides.

Parameters:
- HIGH_FIRST, 1: 1 = high byte emitted first, 0 = low byte first.
- CNT_W, 8: width of the emitted-byte statistics counter (wraps).

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- WORD_IN  input  16  word to unpack
- MODE  input  2  byte transform, sampled with WORD_IN: 00 pass, 01 bit-swap, 10 rotate right by 1, 11 rotate left by 1
- IN_VALID  input  1  WORD_IN/MODE valid
- IN_READY  output  1  block accepts a word this cycle
- BYTE_OUT  output  8  current output byte (transformed)
- HIGH_NIBBLE  output  4  BYTE_OUT[7:4]
- LOW_NIBBLE  output  4  BYTE_OUT[3:0]
- OUT_VALID  output  1  BYTE_OUT valid
- OUT_READY  input  1  consumer accepts BYTE_OUT
- OUT_LAST  output  1  BYTE_OUT is the second byte of its word
- BYTE_CNT  output  CNT_W  count of bytes transferred (OUT_VALID & OUT_READY)

Behaviour:
- Reset (asynchronous, RST=1), all outputs and state cleared immediately:
  - state=IDLE
  - OUT_VALID=0, OUT_LAST=0, BYTE_OUT=0, nibbles=0, BYTE_CNT=0
  - internal word and mode registers = 0
  - IN_READY=0 while RST=1; IN_READY=1 in the first cycle after release.
- States:
  - IDLE: OUT_VALID=0, IN_READY=1.
    - IN_VALID=1: latch WORD_IN and MODE, go to FIRST.
  - FIRST: OUT_VALID=1, OUT_LAST=0.
    - BYTE_OUT = transform(first byte): WORD_IN[15:8] if HIGH_FIRST=1, else [7:0].
    - OUT_READY=1: go to SECOND.
    - OUT_READY=0: hold; BYTE_OUT stays stable.
  - SECOND: OUT_VALID=1, OUT_LAST=1.
    - BYTE_OUT = transform(other byte).
    - OUT_READY=1 and IN_VALID=1: latch the new word, go to FIRST (back-to-back, no bubble).
    - OUT_READY=1 and IN_VALID=0: go to IDLE.
    - OUT_READY=0: hold.
- IN_READY = (state==IDLE) | (state==SECOND & OUT_READY). This is a combinational path from OUT_READY to IN_READY, which is accepted.
- Latency: word accepted in cycle N, first byte valid in cycle N+1. Sustained throughput is 1 byte/cycle, i.e. 1 word per 2 cycles.
- Transform definitions, for byte b[7:0]:
  - bit-swap: {b[0],b[1],b[2],b[3],b[4],b[5],b[6],b[7]}
  - rotate right by 1: {b[0],b[7:1]}
  - rotate left by 1: {b[6:0],b[7]}
- Transform is combinational from the latched byte and latched MODE. MODE changes while a word is in flight have no effect.
- HIGH_NIBBLE and LOW_NIBBLE always equal the split of BYTE_OUT, including the zero values in IDLE.
- BYTE_OUT reads 0 whenever OUT_VALID=0.
- Stability: while OUT_VALID=1 and OUT_READY=0, BYTE_OUT, OUT_LAST and the nibbles must not change.
- BYTE_CNT increments by 1 on each OUT_VALID&OUT_READY cycle and wraps from 2^CNT_W-1 to 0.
- IN_VALID without IN_READY: the word is not consumed; the producer must hold it.
- RST asserted mid-word: the in-flight word is discarded and no partial byte is emitted after release.

Decomposition:
- Shared package (concat_pkg):
  - MODE encodings MODE_PASS, MODE_SWAP, MODE_ROR, MODE_ROL
  - state typedef {IDLE, FIRST, SECOND}
- Sub-module byte_transform: purely combinational, (b, mode) -> transformed byte. It is reusable by the forward concatenation path.
- The FSM, data registers and counter live in word_unpacker.

Test Plan:
- Reset mid-stream: assert RST while in SECOND -> OUT_VALID=0 and BYTE_CNT=0 immediately. After release, IN_READY=1 and no stale byte appears.
- Basic pass, HIGH_FIRST=1, OUT_READY=1: WORD_IN=16'hA53C, MODE=00 -> BYTE_OUT=8'hA5 (OUT_LAST=0, HIGH_NIBBLE=4'hA, LOW_NIBBLE=4'h5), then 8'h3C (OUT_LAST=1). BYTE_CNT=2.
- Transforms on word 16'h8101:
  - MODE=01 -> 8'h81, 8'h80
  - MODE=10 -> 8'hC0, 8'h80
  - MODE=11 -> 8'h03, 8'h02
- Backpressure: OUT_READY held at 0 for 5 cycles during FIRST -> BYTE_OUT stable, IN_READY=0, MODE changes ignored. The stream resumes correctly once OUT_READY=1.
- Back-to-back: IN_VALID held at 1 with words 16'h1122 and 16'h3344, OUT_READY=1 -> bytes 11,22,33,44 on consecutive cycles, OUT_VALID never drops.
- Counter wrap: CNT_W=8, transfer 256 bytes -> BYTE_CNT returns to 0. HIGH_FIRST=0 run with 16'hBEEF -> bytes EF then BE.
